spi_sample_reader: RTL and testbench

// - SPI master that drains 16-bit ADC samples from the FPGA's SPI sample-streaming slave.
// - Drives sclk/SPI_cs into the slave, shifts in processed_MISO and reassembles words.
// - Pulses transaction_done after every word so the streaming FSM advances.
// - Used as on-board loopback reader and as bench stimulus standing in for the Raspberry Pi.

---
 rtl/spi_sample_reader.sv | 167 ++++++++++++++++
 tb/tb_spi_sample_reader.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sample_reader.sv
// SPI master that reads bursts of WORD_BITS-wide samples from the sample-streaming slave.
// sclk idles low, MISO is sampled on the sclk rising edge, MSB first.
module spi_sample_reader #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned WORD_BITS  = 16,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           burst_len,
    output logic                 sclk,
    output logic                 SPI_cs,
    input  logic                 processed_MISO,
    output logic [WORD_BITS-1:0] word_data,
    output logic                 word_valid,
    output logic                 transaction_done,
    output logic                 busy,
    output logic                 burst_done
);

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StSclkLo,
        StSclkHi,
        StCsHold,
        StGap,
        StFinish
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [4:0] BITS     = 5'(WORD_BITS);

    state_t               state;
    logic [7:0]           div_cnt;
    logic [4:0]           bit_cnt;
    logic [7:0]           word_cnt;
    logic [7:0]           burst_len_q;
    logic [WORD_BITS-1:0] shreg;
    logic                 hold_tail;
    logic                 div_done;
    logic                 gap_done;

    always_comb begin
        div_done = (div_cnt == DIV_LAST);
        gap_done = (div_cnt == GAP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= StIdle;
            div_cnt          <= '0;
            bit_cnt          <= '0;
            word_cnt         <= '0;
            burst_len_q      <= '0;
            shreg            <= '0;
            hold_tail        <= 1'b0;
            sclk             <= 1'b0;
            SPI_cs           <= 1'b1;
            word_data        <= '0;
            word_valid       <= 1'b0;
            transaction_done <= 1'b0;
            busy             <= 1'b0;
            burst_done       <= 1'b0;
        end else begin
            word_valid       <= 1'b0;
            transaction_done <= 1'b0;
            burst_done       <= 1'b0;

            case (state)
                StIdle: begin
                    if (start) begin
                        div_cnt   <= '0;
                        bit_cnt   <= '0;
                        word_cnt  <= '0;
                        hold_tail <= 1'b0;
                        if (burst_len == 8'd0) begin
                            state <= StFinish;
                        end else begin
                            burst_len_q <= burst_len;
                            busy        <= 1'b1;
                            SPI_cs      <= 1'b0;
                            state       <= StCsSetup;
                        end
                    end
                end

                // Raising sclk and sampling MISO happen on the same clk edge.
                StCsSetup, StSclkLo: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        shreg   <= {shreg[WORD_BITS-2:0], processed_MISO};
                        bit_cnt <= bit_cnt + 5'd1;
                        state   <= StSclkHi;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                StSclkHi: begin
                    if (div_done) begin
                        div_cnt   <= '0;
                        sclk      <= 1'b0;
                        hold_tail <= 1'b0;
                        if (bit_cnt < BITS) begin
                            state <= StSclkLo;
                        end else begin
                            state <= StCsHold;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                // Spans the trailing sclk-low half-period and then the CS hold time,
                // giving a word period of (2*WORD_BITS+2)*CLK_DIV + GAP_CYCLES.
                StCsHold: begin
                    if (div_done) begin
                        div_cnt <= '0;
                        if (!hold_tail) begin
                            hold_tail <= 1'b1;
                        end else begin
                            hold_tail        <= 1'b0;
                            SPI_cs           <= 1'b1;
                            word_data        <= shreg;
                            word_valid       <= 1'b1;
                            transaction_done <= 1'b1;
                            word_cnt         <= word_cnt + 8'd1;
                            state            <= StGap;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                StGap: begin
                    if (gap_done) begin
                        div_cnt <= '0;
                        if (word_cnt < burst_len_q) begin
                            bit_cnt <= '0;
                            SPI_cs  <= 1'b0;
                            state   <= StCsSetup;
                        end else begin
                            state <= StFinish;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end

                StFinish: begin
                    burst_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sample_reader.sv
// Bench for spi_sample_reader: slave models feed MISO, a monitor records words,
// and expectations come from the word-period formula and the words handed to the slave.
module tb_spi_sample_reader;

    localparam int D  = 4;
    localparam int W  = 16;
    localparam int G  = 2;
    localparam int D2 = 2;
    localparam int G2 = 1;
    localparam int P0 = (2 * W + 2) * D;
    localparam int PW = P0 + G;

    typedef struct packed {
        logic [7:0]  len;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [15:0] w3;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  burst_len = 8'd0;
    logic        sclk;
    logic        SPI_cs;
    logic        miso = 1'b0;
    logic [15:0] word_data;
    logic        word_valid;
    logic        tdone;
    logic        busy;
    logic        bdone;

    logic        start2 = 1'b0;
    logic [7:0]  burst_len2 = 8'd0;
    logic        sclk2;
    logic        SPI_cs2;
    logic        miso2 = 1'b0;
    logic [15:0] word_data2;
    logic        word_valid2;
    logic        tdone2;
    logic        busy2;
    logic        bdone2;

    always #5 clk = ~clk;

    spi_sample_reader dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .burst_len        (burst_len),
        .sclk             (sclk),
        .SPI_cs           (SPI_cs),
        .processed_MISO   (miso),
        .word_data        (word_data),
        .word_valid       (word_valid),
        .transaction_done (tdone),
        .busy             (busy),
        .burst_done       (bdone)
    );

    spi_sample_reader #(
        .CLK_DIV    (D2),
        .WORD_BITS  (W),
        .GAP_CYCLES (G2)
    ) dut2 (
        .clk              (clk),
        .rst              (rst),
        .start            (start2),
        .burst_len        (burst_len2),
        .sclk             (sclk2),
        .SPI_cs           (SPI_cs2),
        .processed_MISO   (miso2),
        .word_data        (word_data2),
        .word_valid       (word_valid2),
        .transaction_done (tdone2),
        .busy             (busy2),
        .burst_done       (bdone2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Slave for dut: serves words from slv_q, one per CS-low window, shifting on sclk fall.
    logic [15:0] slv_q[$];
    int          slv_rd = 0;
    logic [15:0] tx_sh = 16'h0;
    int          edges = 0;
    int          hi_len = 0;
    int          windows = 0;
    int          rises = 0;
    int          td_mismatch = 0;
    bit          widths_ok = 1'b1;
    logic        prev_cs = 1'b1;
    logic        prev_sclk = 1'b0;
    logic [15:0] got_data[$];
    int          got_t[$];
    int          got_edges[$];
    bit          got_wok[$];
    bit          got_csrise[$];

    always @(negedge clk) begin
        if (SPI_cs === 1'b0 && prev_cs === 1'b1) begin
            tx_sh     = (slv_rd < slv_q.size()) ? slv_q[slv_rd] : 16'h0;
            slv_rd++;
            miso      = tx_sh[15];
            edges     = 0;
            widths_ok = 1'b1;
            windows++;
        end
        if (sclk === 1'b1) begin
            if (prev_sclk !== 1'b1) begin
                edges++;
                rises++;
                hi_len = 1;
            end else begin
                hi_len++;
            end
        end else if (prev_sclk === 1'b1) begin
            if (hi_len != D) widths_ok = 1'b0;
            if (SPI_cs === 1'b0) begin
                tx_sh = tx_sh << 1;
                miso  = tx_sh[15];
            end
        end
        if (word_valid !== tdone) td_mismatch++;
        if (word_valid === 1'b1) begin
            got_data.push_back(word_data);
            got_t.push_back(cyc);
            got_edges.push_back(edges);
            got_wok.push_back(widths_ok);
            got_csrise.push_back(SPI_cs === 1'b1 && prev_cs === 1'b0);
        end
        prev_cs   = SPI_cs;
        prev_sclk = sclk;
    end

    // Slave for dut2: always returns 0xA5C3.
    logic [15:0] tx2_sh = 16'h0;
    logic        prev_cs2 = 1'b1;
    logic        prev_sclk2 = 1'b0;

    always @(negedge clk) begin
        if (SPI_cs2 === 1'b0 && prev_cs2 === 1'b1) begin
            tx2_sh = 16'hA5C3;
            miso2  = tx2_sh[15];
        end else if (sclk2 === 1'b0 && prev_sclk2 === 1'b1 && SPI_cs2 === 1'b0) begin
            tx2_sh = tx2_sh << 1;
            miso2  = tx2_sh[15];
        end
        prev_cs2   = SPI_cs2;
        prev_sclk2 = sclk2;
    end

    task automatic run_burst(input logic [7:0] len, input bit spam);
        int          base_s, base_g, win0, rise0, tdm0, c0, t_done, n, limit, exp_done;
        bit          seen;
        logic [15:0] exp_w;
        base_s = slv_rd;
        base_g = got_data.size();
        win0   = windows;
        rise0  = rises;
        tdm0   = td_mismatch;
        @(negedge clk);
        start     = 1'b1;
        burst_len = len;
        c0        = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'(len != 8'd0));
        seen   = 1'b0;
        t_done = 0;
        limit  = (int'(len) + 1) * (PW + 20);
        for (int i = 0; i < limit; i++) begin
            if (bdone === 1'b1) begin
                seen   = 1'b1;
                t_done = cyc;
                break;
            end
            if (spam && (i % 40) == 20) begin
                start     = 1'b1;
                burst_len = len + 8'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL burst_done_timeout: none within %0d cycles, required one", limit);
            return;
        end
        exp_done = (len == 8'd0) ? c0 + 1 : c0 + P0 + (int'(len) - 1) * PW + G + 1;
        check("busy_at_done", 32'(busy), 32'(0));
        check("burst_done_time", t_done, exp_done);
        n = got_data.size() - base_g;
        check("word_count", n, int'(len));
        check("cs_windows", windows - win0, int'(len));
        check("sclk_rises", rises - rise0, W * int'(len));
        check("valid_done_agree", td_mismatch - tdm0, 0);
        for (int k = 0; k < n && k < int'(len); k++) begin
            exp_w = (base_s + k < slv_q.size()) ? slv_q[base_s + k] : 16'h0;
            check("word_data", 32'(got_data[base_g + k]), 32'(exp_w));
            check("word_time", got_t[base_g + k], c0 + P0 + k * PW);
            check("edges_per_word", got_edges[base_g + k], W);
            check("sclk_high_width", 32'(got_wok[base_g + k]), 32'(1));
            check("cs_rise_with_valid", 32'(got_csrise[base_g + k]), 32'(1));
        end
        @(negedge clk);
        check("burst_done_one_cycle", 32'(bdone), 32'(0));
        check("busy_after_done", 32'(busy), 32'(0));
    endtask

    vec_t        vecs[6];
    logic [15:0] ws[4];

    initial begin
        vecs[0] = '{len: 8'd3, w0: 16'h0001, w1: 16'h8000, w2: 16'hFFFF, w3: 16'h0000};
        vecs[1] = '{len: 8'd1, w0: 16'hA5C3, w1: 16'h0000, w2: 16'h0000, w3: 16'h0000};
        vecs[2] = '{len: 8'd0, w0: 16'h0000, w1: 16'h0000, w2: 16'h0000, w3: 16'h0000};
        for (int i = 3; i < 6; i++) begin
            vecs[i].len = 8'($urandom_range(1, 4));
            vecs[i].w0  = 16'($urandom);
            vecs[i].w1  = 16'($urandom);
            vecs[i].w2  = 16'($urandom);
            vecs[i].w3  = 16'($urandom);
        end

        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk), 32'(0));
        check("rst_cs", 32'(SPI_cs), 32'(1));
        check("rst_word_data", 32'(word_data), 32'(0));
        check("rst_word_valid", 32'(word_valid), 32'(0));
        check("rst_tdone", 32'(tdone), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_burst_done", 32'(bdone), 32'(0));
        check("rst_cs2", 32'(SPI_cs2), 32'(1));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        begin : div2_word
            int   c0, t;
            bit   seen;
            logic p_cs;
            start2     = 1'b1;
            burst_len2 = 8'd1;
            c0         = cyc + 1;
            @(negedge clk);
            start2 = 1'b0;
            seen   = 1'b0;
            t      = 0;
            p_cs   = SPI_cs2;
            for (int i = 0; i < 200; i++) begin
                if (word_valid2 === 1'b1) begin
                    seen = 1'b1;
                    t    = cyc;
                    break;
                end
                p_cs = SPI_cs2;
                @(negedge clk);
            end
            check("d2_valid_seen", 32'(seen), 32'(1));
            check("d2_word_data", 32'(word_data2), 32'h0000A5C3);
            check("d2_valid_time", t, c0 + (2 * W + 2) * D2);
            check("d2_cs_rise", 32'({SPI_cs2, p_cs}), 32'(2'b10));
            check("d2_tdone_with_valid", 32'(tdone2), 32'(1));
            @(negedge clk);
            check("d2_valid_one_cycle", 32'(word_valid2), 32'(0));
            @(negedge clk);
            check("d2_burst_done", 32'(bdone2), 32'(1));
        end

        for (int i = 0; i < 6; i++) begin
            ws[0] = vecs[i].w0;
            ws[1] = vecs[i].w1;
            ws[2] = vecs[i].w2;
            ws[3] = vecs[i].w3;
            for (int k = 0; k < int'(vecs[i].len); k++) slv_q.push_back(ws[k[1:0]]);
            run_burst(vecs[i].len, 1'b0);
        end

        // start pulses during a burst must neither extend nor restart it
        slv_q.push_back(16'($urandom));
        slv_q.push_back(16'($urandom));
        run_burst(8'd2, 1'b1);

        begin : reset_mid_word
            int          base_g;
            bit          hit, saw_done;
            logic [15:0] w0;
            w0 = 16'($urandom);
            slv_q.push_back(w0);
            slv_q.push_back(16'($urandom));
            slv_q.push_back(16'($urandom));
            base_g = got_data.size();
            @(negedge clk);
            start     = 1'b1;
            burst_len = 8'd3;
            @(negedge clk);
            start = 1'b0;
            hit   = 1'b0;
            for (int i = 0; i < 2 * PW; i++) begin
                if (got_data.size() == base_g + 1 && SPI_cs === 1'b0 && edges == 7) begin
                    hit = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("reached_bit7_word2", 32'(hit), 32'(1));
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("midrst_cs", 32'(SPI_cs), 32'(1));
            check("midrst_sclk", 32'(sclk), 32'(0));
            check("midrst_busy", 32'(busy), 32'(0));
            check("midrst_word_valid", 32'(word_valid), 32'(0));
            check("midrst_burst_done", 32'(bdone), 32'(0));
            saw_done = 1'b0;
            repeat (2 * PW) begin
                @(negedge clk);
                if (bdone === 1'b1) saw_done = 1'b1;
            end
            check("midrst_no_burst_done", 32'(saw_done), 32'(0));
            check("midrst_words", got_data.size() - base_g, 1);
            check("midrst_first_word", 32'(got_data[base_g]), 32'(w0));
            run_burst(8'd1, 1'b0);
        end

        for (int k = 0; k < 255; k++) slv_q.push_back(16'($urandom));
        run_burst(8'd255, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
